// File: rtl/parity_engine.sv
// parity_engine: serial parity generator/checker for the UART datapath.
// Accumulates parity one bit at a time over a frame of 0..MAX_WIDTH bits,
// produces even/odd/mark/space parity, and checks received parity bits
// against the result with a saturating error counter.
//
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   PAR_EN          gates acceptance of start
//   par_mode        00 even, 01 odd, 10 mark, 11 space (latched on start)
//   data_len        frame length in bits (latched on start, clamped)
//   start           begin/restart a frame
//   bit_valid,bit_in  serial frame bit
//   chk_valid,chk_bit received parity bit to compare in READY
//   err_clr         clear err_cnt
//   busy            high while accumulating
//   par_done        one-cycle pulse on entry to READY
//   par_bit         parity result, stable in READY
//   par_err         one-cycle pulse on a parity mismatch
//   err_cnt         saturating mismatch count
module parity_engine #(
    parameter int unsigned MAX_WIDTH = 8,
    parameter int unsigned LEN_W     = $clog2(MAX_WIDTH + 1),
    parameter int unsigned ERR_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PAR_EN,
    input  logic [1:0]       par_mode,
    input  logic [LEN_W-1:0] data_len,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             chk_valid,
    input  logic             chk_bit,
    input  logic             err_clr,
    output logic             busy,
    output logic             par_done,
    output logic             par_bit,
    output logic             par_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam logic [1:0] MODE_EVEN  = 2'd0;
    localparam logic [1:0] MODE_ODD   = 2'd1;
    localparam logic [1:0] MODE_MARK  = 2'd2;
    localparam logic [1:0] MODE_SPACE = 2'd3;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WIDTH);
    localparam logic [ERR_W-1:0] ERR_SAT = {ERR_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             busy_d, par_done_d, par_bit_d, par_err_d;
    logic [ERR_W-1:0] err_cnt_d;

    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] cnt_inc;
    logic             acc_next;
    logic             mismatch;

    // Final parity from the accumulated XOR; mark/space ignore the data.
    function automatic logic parity_result(input logic [1:0] mode, input logic acc);
        logic res;
        res = 1'b0;
        case (mode)
            MODE_EVEN:  res = acc;
            MODE_ODD:   res = ~acc;
            MODE_MARK:  res = 1'b1;
            MODE_SPACE: res = 1'b0;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

    assign len_clamped = (data_len > LEN_MAX) ? LEN_MAX : data_len;
    assign cnt_inc     = cnt_q + LEN_W'(1);
    assign acc_next    = acc_q ^ bit_in;
    // Compared against the registered par_bit, so a coincident restart
    // is checked against the result of the frame just finished.
    assign mismatch    = (state_q == S_READY) && chk_valid && (chk_bit != par_bit);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        par_bit_d  = par_bit;
        par_done_d = 1'b0;
        err_cnt_d  = err_cnt;

        // start has priority over any bit presented in the same cycle.
        if (start) begin
            if (PAR_EN) begin
                mode_d = par_mode;
                len_d  = len_clamped;
                cnt_d  = '0;
                acc_d  = 1'b0;
                if (len_clamped == '0) begin
                    state_d    = S_READY;
                    par_bit_d  = parity_result(par_mode, 1'b0);
                    par_done_d = 1'b1;
                end else begin
                    state_d = S_ACCUM;
                end
            end else begin
                state_d = S_IDLE;
            end
        end else if ((state_q == S_ACCUM) && bit_valid) begin
            acc_d = acc_next;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
                state_d    = S_READY;
                par_bit_d  = parity_result(mode_q, acc_next);
                par_done_d = 1'b1;
            end
        end

        busy_d    = (state_d == S_ACCUM);
        par_err_d = mismatch;

        if (err_clr) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt != ERR_SAT)) begin
            err_cnt_d = err_cnt + ERR_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_EVEN;
            len_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            busy     <= 1'b0;
            par_done <= 1'b0;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            busy     <= busy_d;
            par_done <= par_done_d;
            par_bit  <= par_bit_d;
            par_err  <= par_err_d;
            err_cnt  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_parity_engine.sv
// tb_parity_engine: self-checking bench for parity_engine. Expected parity
// results and completion cycles are queued as frames are driven and
// compared whenever the DUT pulses par_done.
module tb_parity_engine;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned ERR_W = 8;

    logic             CLK;
    logic             RST;
    logic             PAR_EN;
    logic [1:0]       par_mode;
    logic [LEN_W-1:0] data_len;
    logic             start;
    logic             bit_valid;
    logic             bit_in;
    logic             chk_valid;
    logic             chk_bit;
    logic             err_clr;
    logic             busy;
    logic             par_done;
    logic             par_bit;
    logic             par_err;
    logic [ERR_W-1:0] err_cnt;

    typedef struct {
        logic par;
        int   cyc;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t sb_e;
    int       cyc      = 0;
    int       n_checks = 0;
    int       n_pass   = 0;
    logic     p;

    parity_engine dut (
        .CLK       (CLK),
        .RST       (RST),
        .PAR_EN    (PAR_EN),
        .par_mode  (par_mode),
        .data_len  (data_len),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .chk_valid (chk_valid),
        .chk_bit   (chk_bit),
        .err_clr   (err_clr),
        .busy      (busy),
        .par_done  (par_done),
        .par_bit   (par_bit),
        .par_err   (par_err),
        .err_cnt   (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Completion monitor: every par_done must match the oldest queued frame.
    always @(negedge CLK) begin
        if (!RST && par_done) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check("par_bit", int'(par_bit), int'(sb_e.par));
                check("done_cycle", cyc, sb_e.cyc);
            end
        end
    end

    // Advance to the next drive point; strobes default low.
    task automatic clk_step();
        @(negedge CLK);
        start     = 1'b0;
        bit_valid = 1'b0;
        chk_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    function automatic logic model_par(input logic [1:0] mode, input logic acc);
        case (mode)
            2'd0:    return acc;
            2'd1:    return ~acc;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive start then the frame bits; gap idle cycles precede each bit.
    task automatic run_frame(input logic [1:0] mode, input int len, input logic [7:0] bits,
                             input int gap, input bit start_bv, output logic exp_par);
        int       eff;
        logic     acc;
        sb_item_t it;
        eff = (len > 8) ? 8 : len;
        acc = 1'b0;
        for (int i = 0; i < eff; i++) acc ^= bits[i];
        exp_par = model_par(mode, acc);
        clk_step();
        start     = 1'b1;
        par_mode  = mode;
        data_len  = LEN_W'(len);
        bit_valid = start_bv;
        bit_in    = 1'b1;
        if (eff == 0) begin
            it.par = exp_par; it.cyc = cyc + 1; sb_q.push_back(it);
        end
        for (int i = 0; i < eff; i++) begin
            clk_step();
            if (i == 0) check("busy_rise", int'(busy), 1);
            for (int g = 0; g < gap; g++) clk_step();
            bit_valid = 1'b1;
            bit_in    = bits[i];
            if (i == eff - 1) begin
                it.par = exp_par; it.cyc = cyc + 1; sb_q.push_back(it);
            end
        end
    endtask

    // Step past the last bit, then confirm busy fell and the done was seen.
    task automatic finish_frame(input logic exp_par);
        clk_step();
        check("busy_fall", int'(busy), 0);
        clk_step();
        check("sb_drained", sb_q.size(), 0);
        check("par_held", int'(par_bit), int'(exp_par));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; PAR_EN = 1'b1; par_mode = 2'd0; data_len = '0;
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        chk_valid = 1'b0; chk_bit = 1'b0; err_clr = 1'b0;
        repeat (3) clk_step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(par_done), 0);
        check("rst_par", int'(par_bit), 0);
        check("rst_err", int'(par_err), 0);
        check("rst_cnt", int'(err_cnt), 0);
        RST = 1'b0;

        // Even and odd, len 8, three ones, contiguous.
        run_frame(2'd0, 8, 8'b0000_1101, 0, 1'b0, p); finish_frame(p);
        check("even8", int'(par_bit), 1);
        run_frame(2'd1, 8, 8'b0000_1101, 0, 1'b0, p); finish_frame(p);
        check("odd8", int'(par_bit), 0);

        // Odd, len 5 with gaps; stray bits in READY leave par_bit alone.
        run_frame(2'd1, 5, 8'b0000_0011, 2, 1'b0, p); finish_frame(p);
        check("odd5", int'(par_bit), 1);
        for (int i = 0; i < 3; i++) begin clk_step(); bit_valid = 1'b1; bit_in = 1'b1; end
        clk_step();
        check("ready_ignore_bits", int'(par_bit), 1);

        // Mark, space, clamped length, zero-length in all modes.
        run_frame(2'd2, 7, 8'b0101_0110, 0, 1'b0, p); finish_frame(p);
        run_frame(2'd3, 7, 8'b0111_1111, 0, 1'b0, p); finish_frame(p);
        run_frame(2'd0, 12, 8'b0000_0111, 0, 1'b0, p); finish_frame(p);
        for (int m = 0; m < 4; m++) begin
            run_frame(2'(m), 0, 8'h00, 0, 1'b0, p); finish_frame(p);
        end

        // Back-to-back frames: second start lands on the par_done cycle.
        run_frame(2'd0, 3, 8'b0000_0001, 0, 1'b0, p);
        run_frame(2'd1, 2, 8'b0000_0011, 0, 1'b0, p); finish_frame(p);

        // Abort after 3 bits, restart odd len 2.
        clk_step(); start = 1'b1; par_mode = 2'd0; data_len = LEN_W'(5);
        for (int i = 0; i < 3; i++) begin clk_step(); bit_valid = 1'b1; bit_in = 1'b1; end
        run_frame(2'd1, 2, 8'b0000_0001, 0, 1'b0, p); finish_frame(p);
        // Restart coincident with a valid 1 bit: that bit must not count.
        clk_step(); start = 1'b1; par_mode = 2'd0; data_len = LEN_W'(4);
        clk_step(); bit_valid = 1'b1; bit_in = 1'b1;
        run_frame(2'd0, 2, 8'b0000_0000, 0, 1'b1, p); finish_frame(p);

        // Parity checking and saturating error count.
        run_frame(2'd0, 1, 8'b0000_0001, 0, 1'b0, p); finish_frame(p);
        clk_step(); chk_valid = 1'b1; chk_bit = 1'b0;
        clk_step();
        check("chk_err_pulse", int'(par_err), 1);
        check("chk_cnt1", int'(err_cnt), 1);
        clk_step();
        check("chk_err_onecyc", int'(par_err), 0);
        chk_valid = 1'b1; chk_bit = 1'b1;
        clk_step();
        check("chk_match", int'(par_err), 0);
        check("chk_cnt_hold", int'(err_cnt), 1);
        for (int i = 0; i < 300; i++) begin clk_step(); chk_valid = 1'b1; chk_bit = 1'b0; end
        clk_step();
        check("chk_sat", int'(err_cnt), 255);
        chk_valid = 1'b1; chk_bit = 1'b0; err_clr = 1'b1;
        clk_step();
        check("clr_cnt", int'(err_cnt), 0);
        check("clr_err_pulse", int'(par_err), 1);
        // Drop to IDLE via start without PAR_EN; checks there are ignored.
        PAR_EN = 1'b0; start = 1'b1;
        clk_step();
        PAR_EN = 1'b1;
        check("noen_busy", int'(busy), 0);
        chk_valid = 1'b1; chk_bit = 1'b0;
        clk_step();
        check("idle_chk_err", int'(par_err), 0);
        check("idle_chk_cnt", int'(err_cnt), 0);

        // Reset mid-ACCUM.
        clk_step(); start = 1'b1; par_mode = 2'd0; data_len = LEN_W'(8);
        for (int i = 0; i < 3; i++) begin clk_step(); bit_valid = 1'b1; bit_in = 1'b1; end
        clk_step();
        check("accum_busy", int'(busy), 1);
        RST = 1'b1;
        clk_step();
        RST = 1'b0;
        check("rstacc_busy", int'(busy), 0);
        check("rstacc_done", int'(par_done), 0);
        for (int i = 0; i < 8; i++) begin clk_step(); bit_valid = 1'b1; bit_in = 1'b1; end
        clk_step();
        check("rstacc_idle", int'(busy), 0);

        // Reset in READY with a nonzero error count.
        run_frame(2'd1, 2, 8'b0000_0000, 0, 1'b0, p); finish_frame(p);
        chk_valid = 1'b1; chk_bit = 1'b0;
        clk_step();
        check("pre_rst_cnt", int'(err_cnt), 1);
        RST = 1'b1;
        clk_step();
        RST = 1'b0;
        check("rstrdy_par", int'(par_bit), 0);
        check("rstrdy_cnt", int'(err_cnt), 0);
        check("rstrdy_err", int'(par_err), 0);
        check("rstrdy_busy", int'(busy), 0);

        // start with PAR_EN low stays idle.
        PAR_EN = 1'b0; start = 1'b1; data_len = LEN_W'(3);
        clk_step();
        check("noen_idle1", int'(busy), 0);
        clk_step();
        check("noen_idle2", int'(busy), 0);
        PAR_EN = 1'b1;
        repeat (3) clk_step();
        check("final_sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
